// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: register address and stall
// bus widths, stall bit positions, stall patterns and FSM state encodings.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int STALL_W    = 6;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [STALL_W-1:0]    stall_t;

  localparam int STALL_PC     = 0;
  localparam int STALL_IF_ID  = 1;
  localparam int STALL_ID_EX  = 2;
  localparam int STALL_EX_MEM = 3;
  localparam int STALL_MEM_WB = 4;

  localparam stall_t STALL_NONE     = 6'b00_0000;
  localparam stall_t STALL_DWAIT    = 6'b01_1111;
  localparam stall_t STALL_LOAD_USE = 6'b00_0011;
  localparam stall_t STALL_IFETCH   = 6'b00_0001;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DWAIT  = 2'd1,
    ST_BUBBLE = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  // A load in EX feeding a used source in ID; x0 is hardwired and never hazards.
  function automatic logic load_use(
    input logic      ex_load,
    input reg_addr_t ex_rd,
    input reg_addr_t rs1,
    input logic      rs1_used,
    input reg_addr_t rs2,
    input logic      rs2_used
  );
    return ex_load && (ex_rd != '0) &&
           ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear on rst.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-memory wait with timeout, taken-branch flush,
// load-use bubble and instruction-fetch wait, plus a stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_i,
  input  logic              i_ack_i,
  input  logic              d_req_i,
  input  logic              d_ack_i,
  input  reg_addr_t         id_rs1_i,
  input  reg_addr_t         id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  reg_addr_t         ex_rd_i,
  input  logic              ex_load_i,
  input  logic              ex_branch_taken_i,
  output stall_t            stall_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o,
  output logic              d_timeout_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next, wait_inc;
  logic              timeout_set;
  logic              d_wait, i_wait, hazard;

  assign d_wait = d_req_i && !d_ack_i;
  assign i_wait = i_req_i && !i_ack_i;
  // The instruction sitting in EX during BUBBLE is the inserted bubble, not a load.
  assign hazard = load_use(ex_load_i, ex_rd_i, id_rs1_i, id_rs1_used_i,
                           id_rs2_i, id_rs2_used_i) && (state != ST_BUBBLE);

  // NOTE: every signal assigned here gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next    = state;
    wait_next     = wait_cnt;
    wait_inc      = '0;
    timeout_set   = 1'b0;
    stall_o       = STALL_NONE;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    if (!rst) begin
      if (state == ST_ERR) begin
        stall_o = STALL_DWAIT;
      end else if (d_wait) begin
        stall_o  = STALL_DWAIT;
        wait_inc = (state == ST_DWAIT) ? wait_cnt + WAIT_W'(1) : WAIT_W'(1);
        wait_next = wait_inc;
        if (wait_inc >= WAIT_W'(TIMEOUT)) begin
          state_next  = ST_ERR;
          timeout_set = 1'b1;
        end else begin
          state_next = ST_DWAIT;
        end
      end else begin
        // Branches held behind a data wait are resolved here on the ack cycle.
        wait_next  = '0;
        state_next = ST_RUN;
        if (ex_branch_taken_i) begin
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
        end else if (hazard) begin
          stall_o       = STALL_LOAD_USE;
          flush_id_ex_o = 1'b1;
          state_next    = ST_BUBBLE;
        end else if (i_wait) begin
          stall_o       = STALL_IFETCH;
          flush_if_id_o = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      d_timeout_o <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (timeout_set) begin
        d_timeout_o <= 1'b1;
      end
    end
  end

  sat_counter #(
    .WIDTH (PERF_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_o[STALL_PC]),
    .count (stall_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: single-cycle vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int PERF_W  = 5;
  localparam int CNT_MAX = (1 << PERF_W) - 1;

  logic              clk;
  logic              rst;
  logic              i_req_i, i_ack_i, d_req_i, d_ack_i;
  logic [4:0]        id_rs1_i, id_rs2_i, ex_rd_i;
  logic              id_rs1_used_i, id_rs2_used_i, ex_load_i, ex_branch_taken_i;
  logic [5:0]        stall_o;
  logic              flush_if_id_o, flush_id_ex_o, d_timeout_o;
  logic [PERF_W-1:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(
    .TIMEOUT (TIMEOUT),
    .PERF_W  (PERF_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_req_i           (i_req_i),
    .i_ack_i           (i_ack_i),
    .d_req_i           (d_req_i),
    .d_ack_i           (d_ack_i),
    .id_rs1_i          (id_rs1_i),
    .id_rs2_i          (id_rs2_i),
    .id_rs1_used_i     (id_rs1_used_i),
    .id_rs2_used_i     (id_rs2_used_i),
    .ex_rd_i           (ex_rd_i),
    .ex_load_i         (ex_load_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .stall_o           (stall_o),
    .flush_if_id_o     (flush_if_id_o),
    .flush_id_ex_o     (flush_id_ex_o),
    .d_timeout_o       (d_timeout_o),
    .stall_cnt_o       (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       i_req, i_ack, d_req, d_ack;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, ld, br;
    logic [5:0] stall;
    logic       fif, fie;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(string name, logic i_req, logic i_ack, logic d_req,
                              logic d_ack, logic [4:0] rs1, logic u1, logic [4:0] rs2,
                              logic u2, logic [4:0] rd, logic ld, logic br,
                              logic [5:0] stall, logic fif, logic fie);
    vec_t v;
    v.name = name; v.i_req = i_req; v.i_ack = i_ack; v.d_req = d_req; v.d_ack = d_ack;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd; v.ld = ld; v.br = br;
    v.stall = stall; v.fif = fif; v.fie = fie;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic idle_inputs();
    i_req_i = 0; i_ack_i = 0; d_req_i = 0; d_ack_i = 0;
    id_rs1_i = 0; id_rs2_i = 0; ex_rd_i = 0;
    id_rs1_used_i = 0; id_rs2_used_i = 0; ex_load_i = 0; ex_branch_taken_i = 0;
  endtask

  task automatic apply(input vec_t v);
    i_req_i = v.i_req; i_ack_i = v.i_ack; d_req_i = v.d_req; d_ack_i = v.d_ack;
    id_rs1_i = v.rs1; id_rs1_used_i = v.u1; id_rs2_i = v.rs2; id_rs2_used_i = v.u2;
    ex_rd_i = v.rd; ex_load_i = v.ld; ex_branch_taken_i = v.br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    rst = 0;
  endtask

  task automatic load_use_inputs();
    idle_inputs();
    ex_load_i = 1; ex_rd_i = 5; id_rs1_i = 5; id_rs1_used_i = 1;
  endtask

  // Behavioural model state (plain counters/flags, reset values).
  int   m_waited, m_cnt;
  bit   m_err, m_bubble;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1;
    idle_inputs();
    tick(); tick();
    rst = 0;

    @(negedge clk);
    check("reset_stall", stall_o, 0);
    check("reset_flush", {flush_if_id_o, flush_id_ex_o}, 0);
    check("reset_timeout", d_timeout_o, 0);
    check("reset_cnt", stall_cnt_o, 0);

    //                name            ireq iack dreq dack rs1 u1 rs2 u2 rd ld br stall  fif fie
    vecs[0]  = mk("idle",           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0);
    vecs[1]  = mk("lu_rs1",         0, 0, 0, 0, 5, 1, 0, 0, 5, 1, 0, 6'h03, 0, 1);
    vecs[2]  = mk("lu_rs2",         0, 0, 0, 0, 1, 1, 7, 1, 7, 1, 0, 6'h03, 0, 1);
    vecs[3]  = mk("lu_unused",      0, 0, 0, 0, 5, 0, 5, 0, 5, 1, 0, 6'h00, 0, 0);
    vecs[4]  = mk("lu_x0",          0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 6'h00, 0, 0);
    vecs[5]  = mk("no_load",        0, 0, 0, 0, 5, 1, 0, 0, 5, 0, 0, 6'h00, 0, 0);
    vecs[6]  = mk("br_and_lu",      0, 0, 0, 0, 5, 1, 0, 0, 5, 1, 1, 6'h00, 1, 1);
    vecs[7]  = mk("branch",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'h00, 1, 1);
    vecs[8]  = mk("iwait",          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'h01, 1, 0);
    vecs[9]  = mk("ifetch_ack",     1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0);
    vecs[10] = mk("dwait_all",      1, 0, 1, 0, 5, 1, 0, 0, 5, 1, 1, 6'h1F, 0, 0);
    vecs[11] = mk("dack_iwait",     1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 6'h01, 1, 0);
    vecs[12] = mk("lu_over_iwait",  1, 0, 0, 0, 3, 0, 9, 1, 9, 1, 0, 6'h03, 0, 1);
    vecs[13] = mk("br_over_iwait",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'h00, 1, 1);

    foreach (vecs[k]) begin
      do_reset();
      apply(vecs[k]);
      @(negedge clk);
      check({vecs[k].name, "_stall"}, stall_o, vecs[k].stall);
      check({vecs[k].name, "_flush"}, {flush_if_id_o, flush_id_ex_o}, {vecs[k].fif, vecs[k].fie});
    end

    // Data wait of 3 cycles, then ack; afterwards a load-use proves state is RUN.
    do_reset();
    d_req_i = 1; d_ack_i = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("dwait3_stall", stall_o, 6'h1F);
      check("dwait3_flush", {flush_if_id_o, flush_id_ex_o}, 0);
      tick();
    end
    d_ack_i = 1;
    @(negedge clk);
    check("dwait3_ack_stall", stall_o, 6'h00);
    tick();
    load_use_inputs();
    @(negedge clk);
    check("dwait3_run_after", stall_o, 6'h03);

    // Branch held behind a data wait is honoured on the ack cycle.
    do_reset();
    d_req_i = 1; ex_branch_taken_i = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("br_dwait_stall", stall_o, 6'h1F);
      check("br_dwait_flush", {flush_if_id_o, flush_id_ex_o}, 0);
      tick();
    end
    d_ack_i = 1;
    @(negedge clk);
    check("br_ack_stall", stall_o, 6'h00);
    check("br_ack_flush", {flush_if_id_o, flush_id_ex_o}, 2'b11);

    // Load-use bubble lasts exactly one cycle.
    do_reset();
    load_use_inputs();
    @(negedge clk);
    check("bubble_first", {stall_o, flush_id_ex_o}, {6'h03, 1'b1});
    tick();
    idle_inputs();
    @(negedge clk);
    check("bubble_cycle", {stall_o, flush_id_ex_o}, 0);
    tick();
    load_use_inputs();
    @(negedge clk);
    check("bubble_back_run", {stall_o, flush_id_ex_o}, {6'h03, 1'b1});

    // Timeout after TIMEOUT wait cycles, held through a late ack, cleared by reset.
    do_reset();
    d_req_i = 1;
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk);
      check("to_pending", {d_timeout_o, stall_o}, {1'b0, 6'h1F});
      tick();
    end
    @(negedge clk);
    check("to_raised", {d_timeout_o, stall_o}, {1'b1, 6'h1F});
    tick();
    d_ack_i = 1;
    @(negedge clk);
    check("to_held", {d_timeout_o, stall_o}, {1'b1, 6'h1F});
    tick();
    rst = 1;
    @(negedge clk);
    check("to_rst_comb", {stall_o, flush_if_id_o, flush_id_ex_o}, 0);
    tick();
    rst = 0;
    idle_inputs();
    @(negedge clk);
    check("to_cleared", {d_timeout_o, stall_o, stall_cnt_o}, 0);

    // Reset mid-DWAIT leaves no residual stall.
    do_reset();
    d_req_i = 1;
    tick(); tick();
    rst = 1;
    @(negedge clk);
    check("rst_dwait_comb", stall_o, 0);
    tick();
    rst = 0;
    idle_inputs();
    i_req_i = 1;
    @(negedge clk);
    check("rst_dwait_run", {stall_o, flush_if_id_o}, {6'h01, 1'b1});

    // Stall counter: 20 cycles, then saturation.
    do_reset();
    i_req_i = 1;
    for (int k = 0; k < 20; k++) tick();
    i_req_i = 0;
    @(negedge clk);
    check("cnt_20", stall_cnt_o, 20);
    tick();
    i_req_i = 1;
    for (int k = 0; k < 15; k++) tick();
    @(negedge clk);
    check("cnt_sat", stall_cnt_o, CNT_MAX);
    tick();
    @(negedge clk);
    check("cnt_sat_hold", stall_cnt_o, CNT_MAX);

    // Randomized traffic against the behavioural model.
    do_reset();
    m_waited = 0; m_cnt = 0; m_err = 0; m_bubble = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] e_stall;
      logic       e_fif, e_fie, lu, n_err, n_bubble;
      int         n_wait;
      rst               = ($urandom_range(0, 49) == 0);
      i_req_i           = 1'($urandom_range(0, 1));
      i_ack_i           = 1'($urandom_range(0, 1));
      d_req_i           = ($urandom_range(0, 3) == 0);
      d_ack_i           = 1'($urandom_range(0, 1));
      id_rs1_i          = 5'($urandom_range(0, 3));
      id_rs2_i          = 5'($urandom_range(0, 3));
      ex_rd_i           = 5'($urandom_range(0, 3));
      id_rs1_used_i     = 1'($urandom_range(0, 1));
      id_rs2_used_i     = 1'($urandom_range(0, 1));
      ex_load_i         = 1'($urandom_range(0, 1));
      ex_branch_taken_i = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      e_stall = 0; e_fif = 0; e_fie = 0;
      n_err = m_err; n_wait = m_waited; n_bubble = 0;
      lu = ex_load_i && (ex_rd_i != 0) &&
           ((id_rs1_used_i && id_rs1_i == ex_rd_i) || (id_rs2_used_i && id_rs2_i == ex_rd_i));
      if (rst) begin
        e_stall = 0;
      end else if (m_err) begin
        e_stall = 6'h1F;
      end else if (d_req_i && !d_ack_i) begin
        e_stall = 6'h1F;
        n_wait  = m_waited + 1;
        if (n_wait >= TIMEOUT) n_err = 1;
      end else begin
        n_wait = 0;
        if (ex_branch_taken_i) begin
          e_fif = 1; e_fie = 1;
        end else if (lu && !m_bubble) begin
          e_stall = 6'h03; e_fie = 1; n_bubble = 1;
        end else if (i_req_i && !i_ack_i) begin
          e_stall = 6'h01; e_fif = 1;
        end
      end
      check("rnd_stall", stall_o, e_stall);
      check("rnd_flush", {flush_if_id_o, flush_id_ex_o}, {e_fif, e_fie});
      check("rnd_timeout", d_timeout_o, m_err);
      check("rnd_cnt", stall_cnt_o, m_cnt);
      if (rst) begin
        m_waited = 0; m_cnt = 0; m_err = 0; m_bubble = 0;
      end else begin
        m_err = n_err; m_waited = n_wait; m_bubble = n_bubble;
        if (e_stall[0] && m_cnt < CNT_MAX) m_cnt++;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
